// File: rtl/cordic_phase_gen_if.sv
// Control/data bundle between the phase generator and its neighbours.
// slave: generator side. master: the controller or testbench driving it.
interface cordic_phase_gen_if;
  logic               start_in;
  logic               stop_in;
  logic signed [19:0] init_phase_in;
  logic signed [19:0] step_in;
  logic        [15:0] count_in;
  logic        [7:0]  rate_div_in;
  logic signed [19:0] data_out;
  logic               enable_out;
  logic               busy_out;
  logic               done_out;

  modport slave (
    input  start_in, stop_in, init_phase_in, step_in, count_in, rate_div_in,
    output data_out, enable_out, busy_out, done_out
  );

  modport master (
    output start_in, stop_in, init_phase_in, step_in, count_in, rate_div_in,
    input  data_out, enable_out, busy_out, done_out
  );
endinterface

// File: rtl/cordic_phase_gen.sv
// Paced burst of wrapped sfix20_En12 phase samples feeding the CORDIC rotator.
// Every output is a flop; next-state logic lives in one always_comb.
module cordic_phase_gen #(
  parameter int PI_Q     = 12868,
  parameter int TWO_PI_Q = 25736
) (
  input  logic              clk,
  input  logic              reset,
  cordic_phase_gen_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  localparam logic signed [20:0] PI_S      = 21'(PI_Q);
  localparam logic signed [20:0] PI_M1     = 21'(PI_Q - 1);
  localparam logic signed [20:0] NEG_PI    = -PI_S;
  localparam logic signed [20:0] NEG_PI_M1 = -PI_M1;
  localparam logic signed [20:0] TWO_PI_S  = 21'(TWO_PI_Q);

  state_e             state_q, state_d;
  logic signed [19:0] phase_q, phase_d;
  logic signed [19:0] step_q, step_d;
  logic        [15:0] remain_q, remain_d;
  logic        [7:0]  rate_q, rate_d;
  logic        [7:0]  div_cnt_q, div_cnt_d;
  logic signed [19:0] data_q, data_d;
  logic               enable_q, enable_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic signed [20:0] init_ext, step_ext, sum;
  logic signed [19:0] init_sat, step_sat, phase_next;

  // Input clamps keep |step| < pi so a single wrap correction always suffices.
  always_comb begin
    init_ext = {bus.init_phase_in[19], bus.init_phase_in};
    step_ext = {bus.step_in[19], bus.step_in};

    if (init_ext > PI_M1)       init_sat = 20'(PI_M1);
    else if (init_ext < NEG_PI) init_sat = 20'(NEG_PI);
    else                        init_sat = 20'(init_ext);

    if (step_ext > PI_M1)          step_sat = 20'(PI_M1);
    else if (step_ext < NEG_PI_M1) step_sat = 20'(NEG_PI_M1);
    else                           step_sat = 20'(step_ext);

    sum = {phase_q[19], phase_q} + {step_q[19], step_q};
    if (sum >= PI_S)        phase_next = 20'(sum - TWO_PI_S);
    else if (sum < NEG_PI)  phase_next = 20'(sum + TWO_PI_S);
    else                    phase_next = 20'(sum);
  end

  // NOTE: every _d gets a default before the case so no path infers a latch.
  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    step_d    = step_q;
    remain_d  = remain_q;
    rate_d    = rate_q;
    div_cnt_d = div_cnt_q;
    data_d    = data_q;
    busy_d    = busy_q;
    enable_d  = 1'b0;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start_in) begin
          state_d   = RUN;
          busy_d    = 1'b1;
          phase_d   = init_sat;
          step_d    = step_sat;
          remain_d  = bus.count_in;
          rate_d    = bus.rate_div_in;
          div_cnt_d = '0;
        end
      end
      RUN: begin
        if (bus.stop_in) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else if (remain_q == '0) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else if (div_cnt_q == '0) begin
          data_d    = phase_q;
          enable_d  = 1'b1;
          phase_d   = phase_next;
          remain_d  = remain_q - 16'd1;
          div_cnt_d = rate_q;
        end else begin
          div_cnt_d = div_cnt_q - 8'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignment only; reset is sampled on the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      phase_q   <= '0;
      step_q    <= '0;
      remain_q  <= '0;
      rate_q    <= '0;
      div_cnt_q <= '0;
      data_q    <= '0;
      enable_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      step_q    <= step_d;
      remain_q  <= remain_d;
      rate_q    <= rate_d;
      div_cnt_q <= div_cnt_d;
      data_q    <= data_d;
      enable_q  <= enable_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.data_out   = data_q;
  assign bus.enable_out = enable_q;
  assign bus.busy_out   = busy_q;
  assign bus.done_out   = done_q;

endmodule
